mem_dados: RTL and testbench



---
 rtl/mem_dados.sv | 59 +++++
 tb/tb_mem_dados.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dados.sv
// mem_dados: 256 x 8 data memory for the single-cycle datapath.
// Writes are synchronous on the rising edge of clock. Reads are combinational
// and gated by MemRead. An asynchronous active-low reset loads every word
// with its own address, so the contents are known after reset.
module mem_dados #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [DATA_WIDTH-1:0] dado_in,
    output logic [DATA_WIDTH-1:0] dado_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage is built from flops rather than block RAM. Reset has to restore
    // every word to a non-zero identity pattern at once, and block RAM
    // cannot do that.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            // Next value of word gi: take dado_in only when this word is addressed for a write.
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (MemWrite && (endereco == ADDR_WIDTH'(gi))) begin
                    mem_d[gi] = dado_in;
                end
            end

            // Word register: reset loads the word's own address. A reset in
            // mid-cycle overrides any pending write.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    mem_q[gi] <= DATA_WIDTH'(gi);
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Combinational read, forced to zero when MemRead is low. Nothing is
    // forwarded from dado_in, so a read of a word being written shows the old
    // value until the clock edge.
    always_comb begin
        dado_out = '0;
        if (MemRead) begin
            dado_out = mem_q[endereco];
        end
    end

endmodule

// File: tb/tb_mem_dados.sv
// Testbench for mem_dados. The stimulus process pushes the expected dado_out
// into a queue. A separate monitor process pops each entry and compares it
// with the DUT output. Random traffic is checked against an array model.
module tb_mem_dados;

    logic       clock;
    logic       reset_n;
    logic       MemWrite;
    logic       MemRead;
    logic [7:0] endereco;
    logic [7:0] dado_in;
    logic [7:0] dado_out;

    mem_dados #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .endereco (endereco),
        .dado_in  (dado_in),
        .dado_out (dado_out)
    );

    typedef struct {
        string      name;
        logic [7:0] exp;
        int         addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model [256];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Let the inputs settle, queue the expected value, then hold the inputs
    // steady long enough for the monitor to sample.
    task automatic expect_out(input string name, input logic [7:0] exp);
        exp_t e;
        #1;
        e.name = name;
        e.exp  = exp;
        e.addr = int'(endereco);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = i;
    endtask

    // Monitor: pop each expectation and compare it with the live DUT output.
    initial begin : monitor
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            n_checks++;
            if (dado_out !== e.exp) begin
                n_fail++;
                $display("FAIL %s addr=%0d: dado_out=%h required=%h at t=%0t",
                         e.name, e.addr, dado_out, e.exp, $time);
            end else begin
                $display("ok   %s addr=%0d dado_out=%h", e.name, e.addr, dado_out);
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int addrs [5];
        logic       we, re;
        logic [7:0] a, d;
        logic [7:0] pre;
        addrs = '{0, 1, 9, 15, 255};

        reset_n  = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        endereco = 8'd0;
        dado_in  = 8'd0;
        #3;
        @(negedge clock);
        reset_n = 1'b1;

        // 1. Contents after reset
        MemRead = 1'b1;
        foreach (addrs[k]) begin
            endereco = 8'(addrs[k]);
            expect_out("reset_contents", 8'(addrs[k]));
        end

        // 2. Write then read, and check that a neighbour is unaffected
        @(negedge clock);
        endereco = 8'd10; dado_in = 8'd2; MemWrite = 1'b1;
        @(posedge clock); #1;
        MemWrite = 1'b0;
        expect_out("write_read", 8'd2);
        endereco = 8'd15;
        expect_out("neighbour", 8'd15);

        // 3. Read gating
        MemRead = 1'b0; endereco = 8'd9;
        expect_out("read_gated", 8'd0);
        MemRead = 1'b1;
        expect_out("read_ungated", 8'd9);

        // 4. Write with MemRead = 0
        @(negedge clock);
        MemRead = 1'b0; endereco = 8'd200; dado_in = 8'hA5; MemWrite = 1'b1;
        expect_out("wr_noread_pre", 8'd0);
        @(posedge clock); #1;
        MemWrite = 1'b0;
        expect_out("wr_noread_post", 8'd0);
        MemRead = 1'b1;
        expect_out("wr_noread_rd", 8'hA5);

        // 5. Read and write the same address
        @(negedge clock);
        endereco = 8'd3; dado_in = 8'h7E; MemWrite = 1'b1;
        expect_out("same_addr_pre", 8'd3);
        @(posedge clock); #1;
        MemWrite = 1'b0;
        expect_out("same_addr_post", 8'h7E);

        // 6. Reset mid-cycle, and writes blocked while reset is held
        @(negedge clock);
        endereco = 8'd10; dado_in = 8'hFF; MemWrite = 1'b1;
        @(posedge clock); #1;
        MemWrite = 1'b0;
        expect_out("wr_ff", 8'hFF);
        reset_n = 1'b0;
        expect_out("async_reset", 8'd10);
        @(negedge clock);
        MemWrite = 1'b1; dado_in = 8'h55;
        @(posedge clock); #1;
        expect_out("write_in_reset", 8'd10);
        @(negedge clock);
        MemWrite = 1'b0;
        reset_n  = 1'b1;
        expect_out("reset_release", 8'd10);
        @(negedge clock);
        MemWrite = 1'b1; dado_in = 8'h55;
        @(posedge clock); #1;
        MemWrite = 1'b0;
        expect_out("first_write_after_reset", 8'h55);

        // Random traffic checked against the array model. The pattern is
        // re-established first so the model starts from known contents.
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int it = 0; it < 400; it++) begin
            @(negedge clock);
            we = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            d  = 8'($urandom);
            MemWrite = we; MemRead = re; endereco = a; dado_in = d;
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
            pre = re ? 8'(model[a]) : 8'd0;
            expect_out("rand_pre", pre);
            @(posedge clock); #1;
            if (reset_n && we) model[a] = int'(d);
            expect_out("rand_post", re ? 8'(model[a]) : 8'd0);
            reset_n = 1'b1;
        end

        // Final sweep of the whole array
        @(negedge clock);
        MemWrite = 1'b0; MemRead = 1'b1;
        for (int i = 0; i < 256; i += 17) begin
            endereco = 8'(i);
            expect_out("final_sweep", 8'(model[i]));
        end

        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
